// File: rtl/slc3_pkg.sv
// Shared definitions for the SLC-3 memory/IO bridge.
//   state_e         : bridge FSM states (program copy, then normal CPU service)
//   IO_ADDR_DEFAULT : memory-mapped switch / hex-display word address
package slc3_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/mem_io_bridge_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears both stages
//   d_i   : asynchronous input bus
//   q_o   : synchronized output (two clk edges of latency)
module sync_2ff #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_io_bridge.sv
// Bridge between the CPU memory port, a word RAM, a program ROM and the
// memory-mapped switch/hex IO location.
// After reset it copies INIT_WORDS words ROM->RAM (init_busy=1 holds the CPU
// in reset), then services one CPU request per cycle:
//   clk, reset                  : clock, asynchronous active-high reset
//   mem_addr/mem_wdata          : CPU word address / write data
//   mem_mem_ena/mem_wr_ena      : CPU request strobe / write select
//   mem_rdata                   : read data, valid one cycle after a read
//   sw_i / hex_o                : board switches in / hex display register out
//   init_busy                   : program copy in progress
//   rom_addr/rom_data           : program ROM (combinational read)
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata : synchronous RAM port
module mem_io_bridge #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned INIT_WORDS = 256,
  parameter logic [15:0] IO_ADDR    = slc3_pkg::IO_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  input  logic              mem_mem_ena,
  input  logic              mem_wr_ena,
  output logic [15:0]       mem_rdata,
  input  logic [15:0]       sw_i,
  output logic [15:0]       hex_o,
  output logic              init_busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata
);

  import slc3_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(INIT_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [15:0]       hex_q, hex_d;
  logic [15:0]       io_q, io_d;
  logic              sel_q, sel_d;
  logic [15:0]       sw_sync;
  logic              is_io;

  sync_2ff #(.WIDTH(16)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw_i),
    .q_o   (sw_sync)
  );

  assign is_io = (mem_addr == IO_ADDR);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hex_d     = hex_q;
    io_d      = io_q;
    sel_d     = sel_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    rom_addr  = cnt_q;

    unique case (state_q)
      ST_INIT: begin
        // Reset forces INIT asynchronously; gating with reset keeps the
        // copy write strobe quiet for as long as reset is held.
        ram_en    = !reset;
        ram_we    = !reset;
        ram_addr  = cnt_q;
        ram_wdata = rom_data;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_WORD) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mem_mem_ena) begin
          if (is_io) begin
            if (mem_wr_ena) begin
              hex_d = mem_wdata;
            end else begin
              io_d = sw_sync;
            end
          end else begin
            ram_en    = 1'b1;
            ram_we    = mem_wr_ena;
            ram_addr  = mem_addr[ADDR_W-1:0];
            ram_wdata = mem_wdata;
          end
          // Only reads move the return-data mux, so mem_rdata holds across
          // writes and idle cycles.
          if (!mem_wr_ena) begin
            sel_d = is_io;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      hex_q   <= '0;
      io_q    <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      io_q    <= io_d;
      sel_q   <= sel_d;
    end
  end

  assign init_busy = (state_q == ST_INIT);
  assign hex_o     = hex_q;
  assign mem_rdata = (state_q == ST_RUN) ? (sel_q ? io_q : ram_rdata) : '0;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge with a 4-word program image.
module tb_mem_io_bridge;

  localparam int AW = 10;
  localparam int NW = 4;
  localparam int RAM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   mem_addr, mem_wdata, mem_rdata, sw_i, hex_o;
  logic          mem_mem_ena, mem_wr_ena, init_busy;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [15:0]   rom_data, ram_wdata;
  logic [15:0]   ram_rdata = 16'h0;
  logic          ram_en, ram_we;

  always #5 clk = ~clk;

  mem_io_bridge #(.ADDR_W(AW), .INIT_WORDS(NW), .IO_ADDR(16'hFFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_mem_ena (mem_mem_ena),
    .mem_wr_ena  (mem_wr_ena),
    .mem_rdata   (mem_rdata),
    .sw_i        (sw_i),
    .hex_o       (hex_o),
    .init_busy   (init_busy),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // Program ROM (combinational) and synchronous RAM attached to the DUT.
  logic [15:0] rom_img [NW] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] ram_arr [RAM_WORDS];

  assign rom_data = (int'(rom_addr) < NW) ? rom_img[rom_addr[1:0]] : 16'h0;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_arr[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_arr[ram_addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what the bridge must look like after each edge.
  bit          m_run, m_sel, m_valid;
  int          m_cnt;
  logic [15:0] m_hex, m_sw1, m_sw2, m_io, m_ramval;
  logic [15:0] ref_mem [RAM_WORDS];
  int          wr_cnt;

  task automatic model_step();
    int a;
    if (reset) begin
      m_run = 0; m_cnt = 0; m_hex = 0; m_sw1 = 0; m_sw2 = 0;
      m_io = 0; m_sel = 0; m_valid = 0;
      return;
    end
    if (!m_run) begin
      ref_mem[m_cnt] = rom_img[m_cnt];
      m_cnt++;
      if (m_cnt == NW) m_run = 1;
    end else if (mem_mem_ena) begin
      if (mem_addr == 16'hFFFF) begin
        if (mem_wr_ena) m_hex = mem_wdata;
        else begin m_io = m_sw2; m_sel = 1; m_valid = 1; end
      end else begin
        a = int'(mem_addr) % RAM_WORDS;
        if (mem_wr_ena) ref_mem[a] = mem_wdata;
        else begin m_ramval = ref_mem[a]; m_sel = 0; m_valid = 1; end
      end
    end
    // switches reach the io capture two edges after being sampled
    m_sw2 = m_sw1;
    m_sw1 = sw_i;
  endtask

  task automatic count_writes();
    if (!reset && ram_en && ram_we) wr_cnt++;
  endtask

  always @(posedge clk or posedge reset) model_step();
  always @(posedge clk) count_writes();

  task automatic compare();
    bit req;
    if (reset) begin
      chk("rst_busy", init_busy, 1);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_hex", hex_o, 0);
      chk("rst_rdata", mem_rdata, 0);
    end else if (!m_run) begin
      chk("init_busy", init_busy, 1);
      chk("init_ram_en", ram_en, 1);
      chk("init_ram_we", ram_we, 1);
      chk("init_ram_addr", ram_addr, m_cnt);
      chk("init_rom_addr", rom_addr, m_cnt);
      chk("init_wdata", ram_wdata, rom_img[m_cnt]);
      chk("init_rdata", mem_rdata, 0);
      chk("init_hex", hex_o, m_hex);
    end else begin
      req = mem_mem_ena && (mem_addr != 16'hFFFF);
      chk("run_busy", init_busy, 0);
      chk("run_ram_en", ram_en, req);
      chk("run_ram_we", ram_we, req && mem_wr_ena);
      if (req) begin
        chk("run_ram_addr", ram_addr, int'(mem_addr) % RAM_WORDS);
        chk("run_ram_wdata", ram_wdata, mem_wdata);
      end
      chk("run_hex", hex_o, m_hex);
      if (m_valid) chk("run_rdata", mem_rdata, m_sel ? m_io : m_ramval);
    end
  endtask

  always @(negedge clk) compare();

  task automatic req_cycle(input logic [15:0] a, input logic [15:0] d, input bit w);
    mem_mem_ena = 1'b1;
    mem_addr    = a;
    mem_wdata   = d;
    mem_wr_ena  = w;
    @(posedge clk); #1;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) begin
      ram_arr[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    reset = 1'b1; mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    mem_addr = 16'h0; mem_wdata = 16'h0; sw_i = 16'h0;
    repeat (3) @(posedge clk); #1 reset = 1'b0;

    // Interrupt the copy at counter = 2.
    repeat (2) @(posedge clk); #1;
    chk("mid_init_addr", ram_addr, 2);
    reset = 1'b1; #1;
    chk("async_busy", init_busy, 1);
    chk("async_ram_en", ram_en, 0);
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    wr_cnt = 0;
    chk("restart_addr", ram_addr, 0);
    repeat (3) @(posedge clk); #1;
    chk("busy_after_3", init_busy, 1);
    @(posedge clk); #1;
    chk("busy_after_4", init_busy, 0);
    chk("init_write_count", wr_cnt, 4);
    for (int i = 0; i < NW; i++) chk("rom_copy", ram_arr[i], 16'h1111 * (i + 1));

    // RAM write then read-back.
    req_cycle(16'h0010, 16'hABCD, 1'b1);
    req_cycle(16'h0010, 16'h0000, 1'b0);
    chk("ram_readback", mem_rdata, 16'hABCD);

    // Switch read through the synchronizer.
    sw_i = 16'h00F0;
    repeat (3) @(posedge clk); #1;
    mem_mem_ena = 1'b1; mem_addr = 16'hFFFF; mem_wr_ena = 1'b0; #1;
    chk("io_read_ram_en", ram_en, 0);
    @(posedge clk); #1;
    mem_mem_ena = 1'b0;
    chk("io_read", mem_rdata, 16'h00F0);
    repeat (2) @(posedge clk); #1;
    chk("io_hold_idle", mem_rdata, 16'h00F0);
    req_cycle(16'h0020, 16'h7777, 1'b1);
    chk("io_hold_write", mem_rdata, 16'h00F0);

    // Hex display write and address aliasing.
    req_cycle(16'hFFFF, 16'h1234, 1'b1);
    chk("hex_write", hex_o, 16'h1234);
    req_cycle(16'h0410, 16'h5A5A, 1'b1);
    chk("alias_ram", ram_arr[16], 16'h5A5A);
    req_cycle(16'h0010, 16'h0000, 1'b0);
    chk("alias_read", mem_rdata, 16'h5A5A);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6)      mem_addr = 16'h0010 + 16'($urandom_range(0, 7)) + 16'($urandom_range(0, 63) << 10);
      else if (r < 8) mem_addr = 16'hFFFF;
      else            mem_addr = 16'($urandom);
      mem_mem_ena = ($urandom_range(0, 9) < 7);
      mem_wr_ena  = $urandom_range(0, 1) == 1;
      mem_wdata   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) sw_i = 16'($urandom);
      @(posedge clk); #1;
    end
    mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;

    // Reset mid-copy clears the display register.
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1 reset = 1'b1; #1;
    chk("reset_hex", hex_o, 0);
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("final_busy", init_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
